alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Reservation station and issue stage that feeds the ALU functional units.
- Accepts renamed ALU instructions from dispatch and holds them until both source operands are available.
- Captures operand values from the writeback broadcast.
- Each cycle it issues the oldest ready entry to the lowest-indexed free ALU, driving the ALU select/opcode/operand/destination interface.

Parameters:
DEPTH, 8, number of station entries (power of two not required, 2..16)
NUM_ALU, 3, number of ALUs; width of the one-hot select
TAG_W, 6, physical register tag width
DATA_W, 32, operand/result width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
disp_valid  in  1  dispatch request this cycle
disp_ready  out  1  station can accept a dispatch (count < DEPTH)
disp_optype  in  4  ALU opcode (1 ADD, 2 ADDI, 3 LUI, 4 ORI, 5 XOR, 6 SRAI)
disp_rs1_tag  in  TAG_W  source 1 physical tag
disp_rs1_rdy  in  1  source 1 value already valid
disp_rs1_val  in  DATA_W  source 1 value (used when rdy)
disp_rs2_tag  in  TAG_W  source 2 physical tag
disp_rs2_rdy  in  1  source 2 value already valid
disp_rs2_val  in  DATA_W  source 2 value
disp_imm  in  DATA_W  immediate
disp_dr  in  TAG_W  destination physical tag
wb_valid  in  1  writeback broadcast valid
wb_tag  in  TAG_W  broadcast tag
wb_data  in  DATA_W  broadcast value
flush  in  1  synchronous squash of all entries
fu_ready  in  NUM_ALU  per-ALU availability
alu_number  out  NUM_ALU  one-hot ALU select; all-zero when idle
optype  out  4  opcode to selected ALU
data_in_sr1  out  DATA_W  operand 1
data_in_sr2  out  DATA_W  operand 2
data_in_imm  out  DATA_W  immediate
dr_in  out  TAG_W  destination tag
rs_count  out  5  occupied entries

Behaviour:
- Reset (rstn low, asynchronous): all entries invalid; rs_count=0; disp_ready=1; alu_number, optype, data_in_sr1, data_in_sr2, data_in_imm and dr_in all 0.
- Storage: age-ordered compacting queue; entry 0 is oldest. Each entry holds valid, optype, two {tag, rdy, val}, imm and dr.
- Dispatch:
  - Accepted when disp_valid && disp_ready.
  - Written at the first free slot after this cycle's compaction.
  - disp_ready = (rs_count < DEPTH), computed from registered state. A same-cycle issue does not free a slot for dispatch.
- Wakeup:
  - On wb_valid with wb_tag != 0, every valid entry with matching tag and rdy=0 captures wb_data and sets rdy.
  - A dispatching instruction whose source tag matches the same-cycle broadcast also captures it.
  - Tag 0 broadcasts are ignored.
- Select (combinational on registered state):
  - Candidate = lowest-index entry with both rdy=1.
  - Target = lowest index i with fu_ready[i]=1.
  - Issue occurs only if both exist. A wakeup is not usable for select until the next cycle, so wakeup-to-issue takes 1 cycle.
- Issue outputs are registered:
  - On the edge after select, alu_number = one-hot target, and the operand, optype and dr fields are loaded from the candidate entry.
  - Otherwise alu_number = 0 and the other outputs hold their previous values.
  - The issued entry is removed; younger entries shift down by one in the same edge.
- At most one issue and one dispatch per cycle. rs_count updates by +1, -1 or 0 accordingly.
- Full: disp_valid ignored, no state change from dispatch.
- Empty: no issue, alu_number=0.
- flush:
  - Clears all entries and alu_number next edge.
  - Dispatch and issue in the same cycle are discarded.
  - rs_count=0 next cycle.
- Opcode is passed through unchecked.
- Reset asserted mid-operation drops all entries immediately.

Decomposition:
- Shared package holds:
  - optype constants OP_ADD=1 .. OP_SRAI=6
  - TAG_W/DATA_W constants
  - packed rs_entry_t struct {valid, optype, src1, src2, imm, dr}
  - src_t {tag, rdy, val}
- One sub-module, rs_select: pure combinational picker that takes entry ready vector and fu_ready, and returns candidate index, target one-hot and issue_fire.

Test Plan:
- Reset, then dispatch ADD dr=5, rs1 rdy val=3, rs2 rdy val=4, fu_ready=3'b111 -> next cycle no issue; following edge alu_number=3'b001, optype=1, sr1=3, sr2=4, dr_in=5; rs_count returns 0.
- Dispatch XOR with rs1_tag=9 not ready, then wb_valid tag=9 data=0xF0 -> issue 1 cycle after the broadcast with sr1=0xF0; a wb with tag=0 never wakes it.
- Three ready entries A,B,C, fu_ready=3'b110 -> A issues to alu_number=3'b010 first, then B, then C, in consecutive cycles (oldest-first order kept).
- Fill 8 entries all not-ready -> disp_ready=0, 9th dispatch ignored, rs_count=8. Wake one entry; it issues and rs_count=7, then disp_ready=1.
- Dispatch with rs2_tag=12 in the same cycle as wb tag=12 data=77 -> entry issues with sr2=77 without any further broadcast.
- flush with 4 entries and a pending select -> alu_number=0 and rs_count=0 next cycle; async rstn pulse mid-stream -> outputs zero immediately.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
// ALU issue queue shared types.
// Entry layout, opcodes and the wakeup helper.
package alu_issue_queue_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LUI  = 4'd3;
  localparam logic [3:0] OP_ORI  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRAI = 4'd6;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              rdy;
    logic [DATA_W-1:0] val;
  } src_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        optype;
    src_t              src1;
    src_t              src2;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  dr;
  } rs_entry_t;

  // Capture a broadcast value into a waiting source; tag 0 never matches.
  function automatic src_t wake(
    input src_t              s,
    input logic              v,
    input logic [TAG_W-1:0]  t,
    input logic [DATA_W-1:0] d
  );
    src_t r;
    r = s;
    if (v && t != '0 && !s.rdy && s.tag == t) begin
      r.rdy = 1'b1;
      r.val = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_queue_select.sv
// ALU issue queue picker.
// Oldest ready entry and lowest free ALU.
module rs_select #(
  parameter int DEPTH   = 8,
  parameter int NUM_ALU = 3,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]   rdy_vec,
  input  logic [NUM_ALU-1:0] fu_ready,
  output logic [IDX_W-1:0]   cand_idx,
  output logic [NUM_ALU-1:0] target,
  output logic               fire
);

  logic have;

  // Descending scans so the lowest index wins.
  always_comb begin
    cand_idx = '0;
    have     = 1'b0;
    target   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy_vec[i]) begin
        cand_idx = IDX_W'(i);
        have     = 1'b1;
      end
    end
    for (int j = NUM_ALU - 1; j >= 0; j--) begin
      if (fu_ready[j]) begin
        target    = '0;
        target[j] = 1'b1;
      end
    end
    fire = have && (|fu_ready);
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station and issue stage.
// Age-ordered compacting queue, one issue and one dispatch per cycle.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_ALU = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               disp_valid,
  output logic               disp_ready,
  input  logic [3:0]         disp_optype,
  input  logic [TAG_W-1:0]   disp_rs1_tag,
  input  logic               disp_rs1_rdy,
  input  logic [DATA_W-1:0]  disp_rs1_val,
  input  logic [TAG_W-1:0]   disp_rs2_tag,
  input  logic               disp_rs2_rdy,
  input  logic [DATA_W-1:0]  disp_rs2_val,
  input  logic [DATA_W-1:0]  disp_imm,
  input  logic [TAG_W-1:0]   disp_dr,
  input  logic               wb_valid,
  input  logic [TAG_W-1:0]   wb_tag,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               flush,
  input  logic [NUM_ALU-1:0] fu_ready,
  output logic [NUM_ALU-1:0] alu_number,
  output logic [3:0]         optype,
  output logic [DATA_W-1:0]  data_in_sr1,
  output logic [DATA_W-1:0]  data_in_sr2,
  output logic [DATA_W-1:0]  data_in_imm,
  output logic [TAG_W-1:0]   dr_in,
  output logic [4:0]         rs_count
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t q   [DEPTH];
  rs_entry_t nxt [DEPTH];
  rs_entry_t ins;
  rs_entry_t pick;

  logic [4:0]         count;
  logic [4:0]         slot;
  logic               accept;
  logic [DEPTH-1:0]   rdy_vec;
  logic [IDX_W-1:0]   cand_idx;
  logic [NUM_ALU-1:0] target;
  logic               fire;

  assign rs_count   = count;
  assign disp_ready = count < 5'(DEPTH);
  assign accept     = disp_valid && disp_ready;
  assign slot       = count - {4'd0, fire};
  assign pick       = q[cand_idx];

  // Entries whose operands are both present.
  always_comb begin
    rdy_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = q[i].valid && q[i].src1.rdy && q[i].src2.rdy;
    end
  end

  rs_select #(
    .DEPTH   (DEPTH),
    .NUM_ALU (NUM_ALU),
    .IDX_W   (IDX_W)
  ) u_sel (
    .rdy_vec  (rdy_vec),
    .fu_ready (fu_ready),
    .cand_idx (cand_idx),
    .target   (target),
    .fire     (fire)
  );

  // Incoming entry, including same-cycle broadcast capture.
  always_comb begin
    ins.valid     = 1'b1;
    ins.optype    = disp_optype;
    ins.src1.tag  = disp_rs1_tag;
    ins.src1.rdy  = disp_rs1_rdy;
    ins.src1.val  = disp_rs1_val;
    ins.src2.tag  = disp_rs2_tag;
    ins.src2.rdy  = disp_rs2_rdy;
    ins.src2.val  = disp_rs2_val;
    ins.imm       = disp_imm;
    ins.dr        = disp_dr;
    ins.src1      = wake(ins.src1, wb_valid, wb_tag, wb_data);
    ins.src2      = wake(ins.src2, wb_valid, wb_tag, wb_data);
  end

  // Wakeup, then compaction past the issued entry, then insertion.
  always_comb begin
    nxt = q;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid) begin
        nxt[i].src1 = wake(q[i].src1, wb_valid, wb_tag, wb_data);
        nxt[i].src2 = wake(q[i].src2, wb_valid, wb_tag, wb_data);
      end
    end
    if (fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(cand_idx)) nxt[i] = nxt[i+1];
      end
      nxt[DEPTH-1] = '0;
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (5'(i) == slot) nxt[i] = ins;
      end
    end
  end

  // Queue state and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
      count <= count + {4'd0, accept} - {4'd0, fire};
    end
  end

  // Registered issue interface; payload holds when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_number  <= '0;
      optype      <= '0;
      data_in_sr1 <= '0;
      data_in_sr2 <= '0;
      data_in_imm <= '0;
      dr_in       <= '0;
    end else if (fire && !flush) begin
      alu_number  <= target;
      optype      <= pick.optype;
      data_in_sr1 <= pick.src1.val;
      data_in_sr2 <= pick.src2.val;
      data_in_imm <= pick.imm;
      dr_in       <= pick.dr;
    end else begin
      alu_number  <= '0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for the ALU issue queue.
// Hand-computed expectations, one checking task.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  logic              clk;
  logic              rstn;
  logic              disp_valid;
  logic              disp_ready;
  logic [3:0]        disp_optype;
  logic [TAG_W-1:0]  disp_rs1_tag;
  logic              disp_rs1_rdy;
  logic [DATA_W-1:0] disp_rs1_val;
  logic [TAG_W-1:0]  disp_rs2_tag;
  logic              disp_rs2_rdy;
  logic [DATA_W-1:0] disp_rs2_val;
  logic [DATA_W-1:0] disp_imm;
  logic [TAG_W-1:0]  disp_dr;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic [2:0]        fu_ready;
  logic [2:0]        alu_number;
  logic [3:0]        optype;
  logic [DATA_W-1:0] data_in_sr1;
  logic [DATA_W-1:0] data_in_sr2;
  logic [DATA_W-1:0] data_in_imm;
  logic [TAG_W-1:0]  dr_in;
  logic [4:0]        rs_count;

  int n_chk;
  int n_pass;

  alu_issue_queue dut (
    .clk          (clk),
    .rstn         (rstn),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_optype  (disp_optype),
    .disp_rs1_tag (disp_rs1_tag),
    .disp_rs1_rdy (disp_rs1_rdy),
    .disp_rs1_val (disp_rs1_val),
    .disp_rs2_tag (disp_rs2_tag),
    .disp_rs2_rdy (disp_rs2_rdy),
    .disp_rs2_val (disp_rs2_val),
    .disp_imm     (disp_imm),
    .disp_dr      (disp_dr),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_data      (wb_data),
    .flush        (flush),
    .fu_ready     (fu_ready),
    .alu_number   (alu_number),
    .optype       (optype),
    .data_in_sr1  (data_in_sr1),
    .data_in_sr2  (data_in_sr2),
    .data_in_imm  (data_in_imm),
    .dr_in        (dr_in),
    .rs_count     (rs_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(
    input logic [3:0]  op,
    input logic [5:0]  t1,
    input logic        r1,
    input logic [31:0] v1,
    input logic [5:0]  t2,
    input logic        r2,
    input logic [31:0] v2,
    input logic [31:0] imm,
    input logic [5:0]  dr
  );
    disp_valid   = 1'b1;
    disp_optype  = op;
    disp_rs1_tag = t1;
    disp_rs1_rdy = r1;
    disp_rs1_val = v1;
    disp_rs2_tag = t2;
    disp_rs2_rdy = r2;
    disp_rs2_val = v2;
    disp_imm     = imm;
    disp_dr      = dr;
  endtask

  task automatic wb(input logic v, input logic [5:0] t, input logic [31:0] d);
    wb_valid = v;
    wb_tag   = t;
    wb_data  = d;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rstn = 1'b0;
    disp_valid = 1'b0;
    disp_optype = '0;
    disp_rs1_tag = '0;
    disp_rs1_rdy = 1'b0;
    disp_rs1_val = '0;
    disp_rs2_tag = '0;
    disp_rs2_rdy = 1'b0;
    disp_rs2_val = '0;
    disp_imm = '0;
    disp_dr = '0;
    wb_valid = 1'b0;
    wb_tag = '0;
    wb_data = '0;
    flush = 1'b0;
    fu_ready = 3'b111;
    tick();
    tick();
    check("rst_count", 32'(rs_count), 0);
    check("rst_ready", 32'(disp_ready), 1);
    check("rst_alu", 32'(alu_number), 0);
    check("rst_op", 32'(optype), 0);
    check("rst_sr1", data_in_sr1, 0);
    check("rst_imm", data_in_imm, 0);
    check("rst_dr", 32'(dr_in), 0);
    rstn = 1'b1;
    tick();

    // Basic ADD: one cycle in the queue, then issue to ALU0.
    disp(OP_ADD, 6'd1, 1'b1, 32'd3, 6'd2, 1'b1, 32'd4, 32'd0, 6'd5);
    tick();
    disp_valid = 1'b0;
    check("add_noiss", 32'(alu_number), 0);
    check("add_cnt1", 32'(rs_count), 1);
    tick();
    check("add_alu", 32'(alu_number), 32'b001);
    check("add_op", 32'(optype), 1);
    check("add_sr1", data_in_sr1, 3);
    check("add_sr2", data_in_sr2, 4);
    check("add_dr", 32'(dr_in), 5);
    check("add_cnt0", 32'(rs_count), 0);

    // XOR waiting on tag 9; tag 0 broadcasts ignored.
    disp(OP_XOR, 6'd9, 1'b0, 32'd0, 6'd3, 1'b1, 32'd5, 32'd0, 6'd7);
    tick();
    disp_valid = 1'b0;
    wb(1'b1, 6'd0, 32'hAA);
    tick();
    check("xor_t0a", 32'(alu_number), 0);
    tick();
    check("xor_t0b", 32'(alu_number), 0);
    wb(1'b1, 6'd9, 32'hF0);
    tick();
    wb(1'b0, 6'd0, 32'd0);
    check("xor_wake", 32'(alu_number), 0);
    tick();
    check("xor_alu", 32'(alu_number), 32'b001);
    check("xor_sr1", data_in_sr1, 32'hF0);
    check("xor_sr2", data_in_sr2, 5);
    check("xor_op", 32'(optype), 5);
    check("xor_dr", 32'(dr_in), 7);
    tick();
    check("idle_alu", 32'(alu_number), 0);
    check("idle_hold", 32'(dr_in), 7);

    // Oldest-first to ALU1 with fu_ready=110.
    fu_ready = 3'b110;
    disp(OP_ADDI, 6'd1, 1'b1, 32'd10, 6'd0, 1'b1, 32'd0, 32'd100, 6'd10);
    tick();
    check("ord_c1", 32'(rs_count), 1);
    check("ord_n1", 32'(alu_number), 0);
    disp(OP_ADDI, 6'd1, 1'b1, 32'd11, 6'd0, 1'b1, 32'd0, 32'd101, 6'd11);
    tick();
    check("ord_a_alu", 32'(alu_number), 32'b010);
    check("ord_a_dr", 32'(dr_in), 10);
    check("ord_a_imm", data_in_imm, 100);
    check("ord_c2", 32'(rs_count), 1);
    disp(OP_ADDI, 6'd1, 1'b1, 32'd12, 6'd0, 1'b1, 32'd0, 32'd102, 6'd12);
    tick();
    disp_valid = 1'b0;
    check("ord_b_dr", 32'(dr_in), 11);
    check("ord_b_sr1", data_in_sr1, 11);
    tick();
    check("ord_c_dr", 32'(dr_in), 12);
    check("ord_c_alu", 32'(alu_number), 32'b010);
    check("ord_c0", 32'(rs_count), 0);

    // Fill to DEPTH with waiting entries.
    for (int k = 0; k < 8; k++) begin
      disp(OP_ADD, 6'(20 + k), 1'b0, 32'd0, 6'd0, 1'b1, 32'd1, 32'd0, 6'(40 + k));
      tick();
    end
    check("full_cnt", 32'(rs_count), 8);
    check("full_rdy", 32'(disp_ready), 0);
    disp(OP_ADD, 6'd28, 1'b1, 32'd0, 6'd0, 1'b1, 32'd1, 32'd0, 6'd48);
    tick();
    disp_valid = 1'b0;
    check("full_9th", 32'(rs_count), 8);
    check("full_noiss", 32'(alu_number), 0);
    wb(1'b1, 6'd23, 32'h55);
    tick();
    wb(1'b0, 6'd0, 32'd0);
    tick();
    check("full_alu", 32'(alu_number), 32'b010);
    check("full_sr1", data_in_sr1, 32'h55);
    check("full_dr", 32'(dr_in), 43);
    check("full_cnt7", 32'(rs_count), 7);
    check("full_rdy1", 32'(disp_ready), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl1_cnt", 32'(rs_count), 0);

    // Same-cycle broadcast captured at dispatch.
    disp(OP_ADD, 6'd1, 1'b1, 32'd1, 6'd12, 1'b0, 32'd0, 32'd0, 6'd50);
    wb(1'b1, 6'd12, 32'd77);
    tick();
    disp_valid = 1'b0;
    wb(1'b0, 6'd0, 32'd0);
    check("byp_cnt", 32'(rs_count), 1);
    tick();
    check("byp_alu", 32'(alu_number), 32'b010);
    check("byp_sr2", data_in_sr2, 77);
    check("byp_dr", 32'(dr_in), 50);

    // Tag-0 source stays asleep; flush with a pending select.
    fu_ready = 3'b111;
    disp(OP_ORI, 6'd0, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 32'd0, 6'd60);
    wb(1'b1, 6'd0, 32'd9);
    tick();
    disp_valid = 1'b0;
    tick();
    wb(1'b0, 6'd0, 32'd0);
    check("t0_noiss", 32'(alu_number), 0);
    check("t0_cnt", 32'(rs_count), 1);
    fu_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      disp(OP_LUI, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 32'(k), 6'(61 + k));
      tick();
    end
    disp_valid = 1'b0;
    check("fl_cnt4", 32'(rs_count), 4);
    fu_ready = 3'b111;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_alu", 32'(alu_number), 0);
    check("fl_cnt", 32'(rs_count), 0);
    tick();
    check("fl_after", 32'(alu_number), 0);

    // Asynchronous reset mid-stream.
    disp(OP_SRAI, 6'd1, 1'b1, 32'd8, 6'd0, 1'b1, 32'd2, 32'd3, 6'd33);
    tick();
    disp(OP_ADD, 6'd4, 1'b0, 32'd0, 6'd0, 1'b1, 32'd2, 32'd0, 6'd34);
    tick();
    disp_valid = 1'b0;
    check("ar_pre_alu", 32'(alu_number), 32'b001);
    check("ar_pre_cnt", 32'(rs_count), 1);
    #2 rstn = 1'b0;
    #1;
    check("ar_alu", 32'(alu_number), 0);
    check("ar_cnt", 32'(rs_count), 0);
    check("ar_sr1", data_in_sr1, 0);
    check("ar_dr", 32'(dr_in), 0);
    check("ar_rdy", 32'(disp_ready), 1);
    rstn = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
